// File: rtl/b5_run_ctrl_pkg.sv
// Shared types and defaults for the modulo-N run controller.
// Imported by the interface, the counter and the controller top.
package b5_run_ctrl_pkg;

   localparam int unsigned DefMod = 5;
   localparam int unsigned DefQw  = 3;
   localparam int unsigned DefNw  = 8;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StPause = 2'd2,
      StFin   = 2'd3
   } state_e;

   function automatic logic is_busy(input state_e s);
      return (s == StRun) || (s == StPause);
   endfunction

endpackage

// File: rtl/b5_run_ctrl_if.sv
// Control/status bundle between a host (buttons, switches or a host FSM)
// and the run controller.
interface b5_run_ctrl_if #(
   parameter int unsigned QW = b5_run_ctrl_pkg::DefQw,
   parameter int unsigned NW = b5_run_ctrl_pkg::DefNw
);

   logic          start;
   logic [NW-1:0] n;
   logic          hold;
   logic          abort;
   logic [QW-1:0] q;
   logic          carry;
   logic          busy;
   logic          paused;
   logic          done;
   logic [NW-1:0] runs;

   modport master (
      output start, n, hold, abort,
      input  q, carry, busy, paused, done, runs
   );

   modport slave (
      input  start, n, hold, abort,
      output q, carry, busy, paused, done, runs
   );

endinterface

// File: rtl/b5_run_ctrl_modn_counter.sv
// Up counter modulo the MOD parameter with synchronous clear; wrap flags
// the enabled top-to-zero transition combinationally.
module b5_run_ctrl_modn_counter #(
   parameter int unsigned MOD = b5_run_ctrl_pkg::DefMod,
   parameter int unsigned QW  = b5_run_ctrl_pkg::DefQw
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          clr,
   output logic [QW-1:0] q,
   output logic          wrap
);

   localparam logic [QW-1:0] QTop = QW'(MOD - 1);

   logic [QW-1:0] q_q;
   logic [QW-1:0] q_d;
   logic          at_top;

   assign at_top = (q_q == QTop);
   assign wrap   = en && at_top;

   // Clear wins over enable so an abort on a wrap edge leaves no trace.
   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (en) begin
         q_d = at_top ? '0 : q_q + QW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/b5_run_ctrl.sv
// Run controller: starts the modulo counter, runs it for N full cycles with
// pause/abort, and reports completion through a BUSY/DONE handshake.
module b5_run_ctrl
   import b5_run_ctrl_pkg::*;
#(
   parameter int unsigned MOD = DefMod,
   parameter int unsigned QW  = DefQw,
   parameter int unsigned NW  = DefNw
) (
   input logic          clk,
   input logic          rst_n,
   b5_run_ctrl_if.slave bus
);

   state_e        state_q, state_d;
   logic [NW-1:0] n_q, n_d;
   logic [NW-1:0] runs_q, runs_d;
   logic          cnt_en;
   logic          cnt_clr;
   logic          wrap;
   logic [QW-1:0] cnt_q;
   logic          carry_q;
   logic          busy_q;
   logic          paused_q;
   logic          done_q;

   b5_run_ctrl_modn_counter #(
      .MOD (MOD),
      .QW  (QW)
   ) u_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (cnt_en),
      .clr   (cnt_clr),
      .q     (cnt_q),
      .wrap  (wrap)
   );

   // Counter controls are kept apart from next-state so wrap feeds forward only.
   always_comb begin
      cnt_en  = 1'b0;
      cnt_clr = 1'b0;
      unique case (state_q)
         StIdle: begin
            cnt_clr = bus.start;
         end
         StRun, StPause: begin
            if (bus.abort) begin
               cnt_clr = 1'b1;
            end else if (!bus.hold) begin
               cnt_en = 1'b1;
            end
         end
         StFin: begin
         end
         default: begin
         end
      endcase
   end

   // PAUSE with HOLD low counts on the releasing edge, so each held cycle
   // costs exactly one extra BUSY cycle.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      runs_d  = runs_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               n_d     = bus.n;
               runs_d  = '0;
               state_d = (bus.n == '0) ? StFin : StRun;
            end
         end
         StRun, StPause: begin
            if (bus.abort) begin
               state_d = StIdle;
            end else if (bus.hold) begin
               state_d = StPause;
            end else begin
               state_d = StRun;
               if (wrap) begin
                  runs_d = (runs_q == '1) ? runs_q : runs_q + NW'(1);
                  if (runs_d == n_q) begin
                     state_d = StFin;
                  end
               end
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         n_q      <= '0;
         runs_q   <= '0;
         carry_q  <= 1'b0;
         busy_q   <= 1'b0;
         paused_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         n_q      <= n_d;
         runs_q   <= runs_d;
         carry_q  <= wrap;
         busy_q   <= is_busy(state_d);
         paused_q <= (state_d == StPause);
         done_q   <= (state_d == StFin);
      end
   end

   assign bus.q      = cnt_q;
   assign bus.carry  = carry_q;
   assign bus.busy   = busy_q;
   assign bus.paused = paused_q;
   assign bus.done   = done_q;
   assign bus.runs   = runs_q;

endmodule

// File: tb/tb_b5_run_ctrl.sv
// Directed bench for b5_run_ctrl: one cycle-level vector table plus a
// hand-written mid-run reset sequence.
module tb_b5_run_ctrl;

   typedef struct {
      string      tag;
      logic       start;
      logic [7:0] n;
      logic       hold;
      logic       abort;
      logic [2:0] q;
      logic       carry;
      logic       busy;
      logic       paused;
      logic       done;
      logic [7:0] runs;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;
   vec_t vecs[$];

   b5_run_ctrl_if #(.QW(3), .NW(8)) bus ();

   b5_run_ctrl #(
      .MOD (5),
      .QW  (3),
      .NW  (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic void add(input string tag, input bit st, input int n, input bit h,
                               input bit a, input int q, input bit c, input bit b,
                               input bit p, input bit d, input int r);
      vec_t v;
      v.tag = tag; v.start = st; v.n = 8'(n); v.hold = h; v.abort = a;
      v.q = 3'(q); v.carry = c; v.busy = b; v.paused = p; v.done = d; v.runs = 8'(r);
      vecs.push_back(v);
   endfunction

   // Plain counting rows q = from..to, busy, no events.
   function automatic void add_count(input string tag, input int n, input int from,
                                     input int to, input int r);
      for (int k = from; k <= to; k++) add(tag, 0, n, 0, 0, k, 0, 1, 0, 0, r);
   endfunction

   task automatic check_outputs(input string tag, input logic [2:0] q, input logic c,
                                input logic b, input logic p, input logic d,
                                input logic [7:0] r);
      check({tag, ".q"}, bus.q, q);
      check({tag, ".carry"}, bus.carry, c);
      check({tag, ".busy"}, bus.busy, b);
      check({tag, ".paused"}, bus.paused, p);
      check({tag, ".done"}, bus.done, d);
      check({tag, ".runs"}, bus.runs, r);
   endtask

   initial begin
      int busy_cnt;
      bit done_seen;

      n_checks = 0;
      n_fail = 0;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.n = 8'd0;
      bus.hold = 1'b0;
      bus.abort = 1'b0;

      // N=2, N changes while running are ignored
      add("t1.acc", 1, 2, 0, 0, 0, 0, 1, 0, 0, 0);
      add_count("t1.c0", 7, 1, 4, 0);
      add("t1.wrap1", 0, 7, 0, 0, 0, 1, 1, 0, 0, 1);
      add_count("t1.c1", 7, 1, 4, 1);
      add("t1.done", 0, 7, 0, 0, 0, 1, 0, 0, 1, 2);
      add("t1.idle", 0, 7, 0, 0, 0, 0, 0, 0, 0, 2);
      // N=0 goes straight to FIN; START held in FIN is ignored
      add("t2.acc", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      add("t2.finign", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add("t2.acc2", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      add("t2.idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // N=1, hold three cycles at Q=2
      add("t3.acc", 1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
      add_count("t3.c", 1, 1, 2, 0);
      for (int k = 0; k < 3; k++) add("t3.hold", 0, 1, 1, 0, 2, 0, 1, 1, 0, 0);
      add("t3.rel", 0, 1, 0, 0, 3, 0, 1, 0, 0, 0);
      add_count("t3.c2", 1, 4, 4, 0);
      add("t3.done", 0, 1, 0, 0, 0, 1, 0, 0, 1, 1);
      add("t3.idle", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      // N=3, abort at Q=3 of the second cycle, then a clean N=1 run
      add("t4.acc", 1, 3, 0, 0, 0, 0, 1, 0, 0, 0);
      add_count("t4.c0", 3, 1, 4, 0);
      add("t4.wrap1", 0, 3, 0, 0, 0, 1, 1, 0, 0, 1);
      add_count("t4.c1", 3, 1, 3, 1);
      add("t4.abort", 0, 3, 0, 1, 0, 0, 0, 0, 0, 1);
      add("t4.idle", 0, 3, 0, 0, 0, 0, 0, 0, 0, 1);
      add("t4.acc2", 1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
      add_count("t4.c2", 1, 1, 4, 0);
      add("t4.done", 0, 1, 0, 0, 0, 1, 0, 0, 1, 1);
      add("t4.idle2", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      // Hold + abort on the completing edge: abort wins
      add("t5.acc", 1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
      add_count("t5.c", 1, 1, 4, 0);
      add("t5.habort", 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
      add("t5.idle", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      // Completion on the edge that releases a pause
      add("t6.acc", 1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
      add_count("t6.c", 1, 1, 4, 0);
      add("t6.hold", 0, 1, 1, 0, 4, 0, 1, 1, 0, 0);
      add("t6.done", 0, 1, 0, 0, 0, 1, 0, 0, 1, 1);
      add("t6.idle", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      // Abort while paused
      add("t7.acc", 1, 2, 0, 0, 0, 0, 1, 0, 0, 0);
      add_count("t7.c", 2, 1, 1, 0);
      add("t7.hold", 0, 2, 1, 0, 1, 0, 1, 1, 0, 0);
      add("t7.pabort", 0, 2, 1, 1, 0, 0, 0, 0, 0, 0);
      add("t7.idle", 0, 2, 0, 0, 0, 0, 0, 0, 0, 0);

      #12;
      check_outputs("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         bus.start = vecs[i].start;
         bus.n     = vecs[i].n;
         bus.hold  = vecs[i].hold;
         bus.abort = vecs[i].abort;
         @(posedge clk);
         #1;
         check_outputs($sformatf("%s[%0d]", vecs[i].tag, i), vecs[i].q, vecs[i].carry,
                       vecs[i].busy, vecs[i].paused, vecs[i].done, vecs[i].runs);
      end

      // Mid-run asynchronous reset at Q=3, START held through release
      bus.start = 1'b1;
      bus.n = 8'd2;
      bus.hold = 1'b0;
      bus.abort = 1'b0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("t8.preq", bus.q, 3'd3);
      #2;
      bus.start = 1'b1;
      bus.n = 8'd4;
      rst_n = 1'b0;
      #1;
      check_outputs("t8.inrst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("t8.idle.busy", bus.busy, 1'b0);
      @(posedge clk);
      #1;
      check_outputs("t8.acc", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
      bus.start = 1'b0;
      busy_cnt = 1;
      done_seen = 1'b0;
      for (int i = 0; i < 40 && !done_seen; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) done_seen = 1'b1;
         else if (bus.busy) busy_cnt++;
      end
      check("t8.done_seen", done_seen, 1'b1);
      check("t8.busy_cycles", busy_cnt, 20);
      check("t8.runs", bus.runs, 8'd4);
      check("t8.carry", bus.carry, 1'b1);
      check("t8.q", bus.q, 3'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/b5_run_ctrl.md
# b5_run_ctrl

Run controller for the modulo-5 counter datapath used across the kit. It owns the counter, starts it on request, and advances it for a programmed number of full 0→4 cycles. It supports pause and abort, and reports completion with a BUSY/DONE handshake. It sits between board-level buttons/switches (or a host FSM) and whatever consumes the 3-bit count, such as the 7-segment or LED drivers.

## Interface
Parameters:
- MOD, 5, counter modulus; Q counts 0..MOD-1
- QW, 3, width of Q; must satisfy 2^QW >= MOD
- NW, 8, width of the run-length input N and the RUNS output

Ports:
- CLK  in  1  single system clock; all state changes on the rising edge
- RST_N  in  1  asynchronous, active-low reset
- START  in  1  level; sampled each edge, accepted only in IDLE
- N  in  NW  number of full counter cycles to run; latched when START is accepted
- HOLD  in  1  level; freezes counting while high during a run
- ABORT  in  1  level; terminates a run without a DONE pulse
- Q  out  QW  current count
- CARRY  out  1  one-cycle pulse when Q wraps MOD-1→0
- BUSY  out  1  high while a run is in progress (RUN or PAUSE)
- PAUSED  out  1  high while in PAUSE
- DONE  out  1  one-cycle completion pulse
- RUNS  out  NW  completed cycles in the current or last run

## Operation
- Reset (asynchronous, RST_N=0) immediately forces:
  - state = IDLE
  - Q=0, CARRY=0, BUSY=0, PAUSED=0, DONE=0, RUNS=0
  - latched N = 0
- FSM states: IDLE, RUN, PAUSE, FIN.
- IDLE:
  - START=1 with N≠0: latch N, clear Q and RUNS, go to RUN.
  - START=1 with N=0: go to FIN. No counting takes place, and RUNS=0.
- RUN:
  - HOLD=0: Q ← (Q==MOD-1) ? 0 : Q+1.
  - On wrap: CARRY=1 for the cycle after the edge, and RUNS ← RUNS+1.
  - If the new RUNS equals the latched N, go to FIN. This edge also performs the wrap.
  - HOLD=1: Q and RUNS hold; go to PAUSE.
- PAUSE: Q and RUNS hold. HOLD=0 returns to RUN; counting resumes on the following edge.
- FIN: DONE=1 and BUSY=0 for exactly one cycle, then IDLE. START is ignored in FIN.
- ABORT:
  - In RUN or PAUSE, ABORT=1 → IDLE. Q is cleared to 0, RUNS holds its value, and no DONE or CARRY is produced.
  - ABORT has priority over HOLD and over run completion on the same edge.
- Priorities on one edge: ABORT > HOLD > count/complete.
- START is ignored outside IDLE, and N changes are ignored outside IDLE.
- Width rules:
  - RUNS saturates at 2^NW-1; this cannot be exceeded because N ≤ 2^NW-1.
  - The Q increment is computed in QW bits and compared against MOD-1, never against 2^QW-1.

## Timing
- All outputs are registered, with no combinational input→output paths.
- START accepted at edge k:
  - Q=0 and BUSY=1 after edge k.
  - Q=1 after edge k+1.
- With no HOLD, BUSY is high for exactly N·MOD cycles.
- The final wrap edge produces the cycle with Q=0, CARRY=1, DONE=1, BUSY=0.
- IDLE is reached one cycle after that, and a new START is accepted at the next edge.
- Each cycle with HOLD=1 sampled in RUN or PAUSE extends BUSY by one cycle.
- PAUSED rises one cycle after HOLD is sampled high and falls one cycle after HOLD is sampled low.
- Mid-run reset: all outputs go to their reset values asynchronously. After release, the controller waits in IDLE; the interrupted run is not resumed.
- RST_N deassertion must meet recovery/removal to CLK. The block does not synchronise RST_N internally; a board-level synchroniser is required.

## Structure
- Shared include `b5_defs.vh`:
  - FSM state encodings S_IDLE, S_RUN, S_PAUSE, S_FIN (2-bit)
  - default MOD/QW/NW constants
- One sub-module, `modn_counter`:
  - parameters MOD and QW
  - ports CLK, RST_N, EN, CLR, Q, WRAP
  - WRAP is combinational (EN && Q==MOD-1)
- `b5_run_ctrl` holds the FSM, the N latch, RUNS, and the output registers.

## Test plan
- Reset, then START=1 for 1 cycle with N=2 → Q sequence 0,1,2,3,4,0,1,2,3,4,0. BUSY high for 10 cycles. CARRY high at both wraps. DONE high only at the second wrap, with RUNS=2.
- START with N=0 → DONE=1 one cycle after acceptance. BUSY never rises, and Q stays 0.
- N=1 with HOLD high for 3 cycles while Q=2 → Q stays 2 and PAUSED=1 for 3 cycles. BUSY total is 8 cycles, and DONE follows.
- N=3 with ABORT at Q=3 in the second cycle → next cycle: IDLE, Q=0, RUNS=1, no DONE. A new START with N=1 then completes normally.
- HOLD and ABORT both asserted on the completing edge (Q=4, RUNS=N-1) → abort wins: no DONE, no CARRY.
- RST_N pulsed low mid-run at Q=3 → all outputs read 0 during reset. After release, START is still held high and a new run starts from Q=0 with a freshly latched N.
